// File: rtl/hammer_pkg.sv
// Shared types and constants for the hammer-test Avalon-MM bridge.
package hammer_pkg;

  localparam int CMD_ADDR_W = 64;
  localparam int CMD_WORD_W = 64;

  localparam logic [2:0] AVM_BURST_ONE = 3'd1;

  function automatic int byteen_width(input int word_width);
    return word_width / 8;
  endfunction

  localparam int BYTEEN_W = byteen_width(CMD_WORD_W);

  // Sized for the widest supported request; narrower instances zero-extend into it.
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] address;
    logic [CMD_WORD_W-1:0] wdata;
    logic                  is_write;
    logic                  keep;
  } cmd_t;

endpackage

// File: rtl/avm_hammer_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; used for read tags and responses.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // A pop on empty is ignored; a push on full is only taken alongside a pop.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/avm_hammer_bridge.sv
// Registers hammer-test read/write requests onto an Avalon-MM master with read credits and a response FIFO.
module avm_hammer_bridge
  import hammer_pkg::*;
#(
  parameter  int ADDR_WIDTH      = CMD_ADDR_W,
  parameter  int AVM_ADDR_WIDTH  = 25,
  parameter  int WORD_WIDTH      = CMD_WORD_W,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [WORD_WIDTH-1:0]     req_wdata,
  input  logic                      req_write,
  input  logic                      req_read,
  input  logic                      req_keep,
  output logic                      req_wait,
  output logic                      rsp_valid,
  output logic [WORD_WIDTH-1:0]     rsp_data,
  input  logic                      rsp_ack,
  output logic [AVM_ADDR_WIDTH-1:0] avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [WORD_WIDTH-1:0]     avm_writedata,
  output logic [WORD_WIDTH/8-1:0]   avm_byteenable,
  output logic [2:0]                avm_burstcount,
  input  logic                      avm_waitrequest,
  input  logic                      avm_readdatavalid,
  input  logic [WORD_WIDTH-1:0]     avm_readdata,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_unexpected_rdv,
  output logic                      err_dual_req
);

  localparam int SUM_W = CNT_W + 2;

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of 2 and at least 2");
  end

  cmd_t             cmd_q, cmd_d;
  logic             cmd_full_q, cmd_full_d;
  logic [CNT_W-1:0] kept_inflight_q, kept_inflight_d;
  logic             err_rdv_q, err_rdv_d;
  logic             err_dual_q, err_dual_d;

  logic             accept, retire, rd_retire, rdv_ok;
  logic             pend_rd, pend_keep, read_ok;
  logic             tag_head, rsp_push, rsp_pop;
  logic [CNT_W-1:0] rsp_count;
  logic [SUM_W-1:0] rd_load, keep_load;

  assign retire    = cmd_full_q & ~avm_waitrequest;
  assign rd_retire = retire & ~cmd_q.is_write;
  assign pend_rd   = cmd_full_q & ~cmd_q.is_write;
  assign pend_keep = pend_rd & cmd_q.keep;
  assign rdv_ok    = avm_readdatavalid & (outstanding != '0);

  // Credits count only registered state, so a return in this cycle frees nothing until the next.
  assign rd_load   = SUM_W'(outstanding) + SUM_W'(pend_rd);
  assign keep_load = SUM_W'(rsp_count) + SUM_W'(kept_inflight_q) + SUM_W'(pend_keep);
  assign read_ok   = (rd_load < SUM_W'(MAX_OUTSTANDING)) &
                     (~req_keep | (keep_load < SUM_W'(MAX_OUTSTANDING)));

  assign req_wait  = (cmd_full_q & avm_waitrequest) | (req_read & ~read_ok);
  assign accept    = (req_read | req_write) & ~req_wait;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cmd_d      = cmd_q;
    cmd_full_d = cmd_full_q;
    if (retire) cmd_full_d = 1'b0;
    if (accept) begin
      cmd_full_d     = 1'b1;
      cmd_d.address  = CMD_ADDR_W'(req_address);
      cmd_d.wdata    = CMD_WORD_W'(req_wdata);
      cmd_d.is_write = req_write;
      cmd_d.keep     = req_keep;
    end
  end

  always_comb begin
    kept_inflight_d = kept_inflight_q
                    + CNT_W'(rd_retire & cmd_q.keep)
                    - CNT_W'(rdv_ok & tag_head);
    err_rdv_d  = err_rdv_q | (avm_readdatavalid & (outstanding == '0));
    err_dual_d = err_dual_q | (accept & req_read & req_write);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q           <= '0;
      cmd_full_q      <= 1'b0;
      kept_inflight_q <= '0;
      err_rdv_q       <= 1'b0;
      err_dual_q      <= 1'b0;
    end else begin
      cmd_q           <= cmd_d;
      cmd_full_q      <= cmd_full_d;
      kept_inflight_q <= kept_inflight_d;
      err_rdv_q       <= err_rdv_d;
      err_dual_q      <= err_dual_d;
    end
  end

  // The tag FIFO occupancy is the outstanding-read count; its head says whether to keep the data.
  sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rd_retire),
    .data_i  (cmd_q.keep),
    .pop_i   (rdv_ok),
    .data_o  (tag_head),
    .count_o (outstanding)
  );

  assign rsp_push = rdv_ok & tag_head;
  assign rsp_pop  = rsp_ack & rsp_valid;

  sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_push),
    .data_i  (avm_readdata),
    .pop_i   (rsp_pop),
    .data_o  (rsp_data),
    .count_o (rsp_count)
  );

  assign rsp_valid          = (rsp_count != '0);
  assign avm_read           = cmd_full_q & ~cmd_q.is_write;
  assign avm_write          = cmd_full_q & cmd_q.is_write;
  assign avm_address        = cmd_q.address[AVM_ADDR_WIDTH-1:0];
  assign avm_writedata      = cmd_q.wdata[WORD_WIDTH-1:0];
  assign avm_byteenable     = '1;
  assign avm_burstcount     = AVM_BURST_ONE;
  assign err_unexpected_rdv = err_rdv_q;
  assign err_dual_req       = err_dual_q;

  // Upper address bits beyond the controller word address are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{req_address, cmd_q.address, cmd_q.wdata};

endmodule

// File: tb/tb_avm_hammer_bridge.sv
// Directed corner cases plus randomized traffic against a memory-level reference model and scoreboard.
module tb_avm_hammer_bridge;
  import hammer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] req_address, req_wdata;
  logic        req_write, req_read, req_keep;
  logic        req_wait, rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_ack;
  logic [24:0] avm_address;
  logic        avm_read, avm_write;
  logic [63:0] avm_writedata;
  logic [BYTEEN_W-1:0] avm_byteenable;
  logic [2:0]  avm_burstcount;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [63:0] avm_readdata;
  logic [3:0]  outstanding;
  logic        err_unexpected_rdv, err_dual_req;

  // Directed phase drives the controller/ack side by hand; random phase hands it to the models.
  logic        ctrl_auto = 1'b0, mon_en = 1'b0;
  logic        man_wr = 1'b0, man_rdv = 1'b0, man_ack = 1'b0;
  logic [63:0] man_rdata = '0;
  logic        auto_wr = 1'b0, auto_rdv = 1'b0, mon_ack = 1'b0;
  logic [63:0] auto_rdata = '0;

  assign avm_waitrequest   = ctrl_auto ? auto_wr    : man_wr;
  assign avm_readdatavalid = ctrl_auto ? auto_rdv   : man_rdv;
  assign avm_readdata      = ctrl_auto ? auto_rdata : man_rdata;
  assign rsp_ack           = mon_en    ? mon_ack    : man_ack;

  always #5 clk = ~clk;

  avm_hammer_bridge dut (
    .clk(clk), .reset(reset),
    .req_address(req_address), .req_wdata(req_wdata), .req_write(req_write),
    .req_read(req_read), .req_keep(req_keep), .req_wait(req_wait),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata),
    .outstanding(outstanding), .err_unexpected_rdv(err_unexpected_rdv),
    .err_dual_req(err_dual_req)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_default(input logic [24:0] k);
    return {7'h5a, k, 7'h3c, ~k};
  endfunction

  // Reference: memory as seen by upstream, updated at request acceptance; kept reads queue their data.
  logic [63:0] ref_mem  [logic [24:0]];
  logic [63:0] exp_q    [$];
  // Controller model: its own memory, updated at the Avalon handshake; in-order returns with random latency.
  logic [63:0] ctrl_mem [logic [24:0]];
  logic [63:0] ctrl_data_q [$];
  int          ctrl_due_q  [$];
  int          cyc_cnt = 0;

  always @(negedge clk) begin
    if (!ctrl_auto) begin
      auto_wr  = 1'b0;
      auto_rdv = 1'b0;
    end else begin
      cyc_cnt++;
      auto_wr = ($urandom_range(0, 3) == 0);
      if ((avm_read || avm_write) && !auto_wr) begin
        if (avm_write) ctrl_mem[avm_address] = avm_writedata;
        else begin
          ctrl_data_q.push_back(ctrl_mem.exists(avm_address) ? ctrl_mem[avm_address]
                                                             : mem_default(avm_address));
          ctrl_due_q.push_back(cyc_cnt + int'($urandom_range(1, 6)));
        end
      end
      auto_rdv = 1'b0;
      if (ctrl_due_q.size() > 0 && ctrl_due_q[0] <= cyc_cnt && $urandom_range(0, 3) != 0) begin
        auto_rdv   = 1'b1;
        auto_rdata = ctrl_data_q.pop_front();
        void'(ctrl_due_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    mon_ack = 1'b0;
    if (mon_en) begin
      check("outstanding_bound", 64'(outstanding > 4'd8), 64'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_extra", 64'(rsp_valid), 64'd0);
        else begin
          check("rsp_data", rsp_data, exp_q[0]);
          if ($urandom_range(0, 1) == 1) begin
            mon_ack = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic idle_req();
    req_read = 1'b0; req_write = 1'b0; req_keep = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; idle_req();
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    logic        pending;
    int          kind;
    logic [24:0] key;
    bit          drained;

    reset = 1'b1; req_address = '0; req_wdata = '0; idle_req();
    do_reset();

    // Reset state and constant outputs.
    check("rst_avm_read", 64'(avm_read), 0);
    check("rst_avm_write", 64'(avm_write), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_outstanding", 64'(outstanding), 0);
    check("rst_req_wait", 64'(req_wait), 0);
    check("rst_errs", 64'({err_unexpected_rdv, err_dual_req}), 0);
    check("byteenable", 64'(avm_byteenable), 64'hff);
    check("burstcount", 64'(avm_burstcount), 1);

    // Stalled write: strobe held 4 cycles with stable address/data.
    man_wr = 1'b1; req_write = 1'b1; req_address = 64'h400; req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    @(negedge clk); idle_req();
    for (int i = 0; i < 4; i++) begin
      check("wr_strobe", 64'(avm_write), 1);
      check("wr_addr", 64'(avm_address), 64'h400);
      check("wr_data", avm_writedata, 64'hA5A5_A5A5_A5A5_A5A5);
      if (i == 3) man_wr = 1'b0;
      #1 check("wr_req_wait", 64'(req_wait), (i < 3) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    check("wr_strobe_drop", 64'(avm_write), 0);

    // Eight hammer reads exhaust credits; one return admits the ninth.
    for (int i = 0; i < 8; i++) begin
      req_read = 1'b1; req_keep = 1'b0; req_address = 64'(i);
      #1 check("credit_ok", 64'(req_wait), 0);
      @(negedge clk);
    end
    check("credit_block_a", 64'(req_wait), 1);
    @(negedge clk);
    check("credit_block_b", 64'(req_wait), 1);
    check("credit_outstanding", 64'(outstanding), 8);
    man_rdv = 1'b1; man_rdata = 64'h77;
    #1 check("credit_no_same_cycle", 64'(req_wait), 1);
    @(negedge clk); man_rdv = 1'b0;
    check("credit_after_ret", 64'(outstanding), 7);
    #1 check("credit_ninth_ok", 64'(req_wait), 0);
    @(negedge clk); idle_req(); man_rdv = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("hammer_no_rsp", 64'(rsp_valid), 0);
    end
    man_rdv = 1'b0;
    check("hammer_drained", 64'(outstanding), 0);

    // Interleaved keep/discard: only data 1 and 3 surface.
    for (int i = 0; i < 4; i++) begin
      req_read = 1'b1; req_keep = (i % 2 == 0); req_address = 64'h10 + 64'(i);
      @(negedge clk);
    end
    idle_req();
    for (int d = 1; d <= 4; d++) begin
      man_rdv = 1'b1; man_rdata = 64'(d);
      @(negedge clk);
    end
    man_rdv = 1'b0;
    check("il_first", rsp_data, 1);
    @(negedge clk);
    check("il_first_held", rsp_data, 1);
    check("il_valid_held", 64'(rsp_valid), 1);
    man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
    check("il_second", rsp_data, 3);
    check("il_second_valid", 64'(rsp_valid), 1);
    man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
    check("il_empty", 64'(rsp_valid), 0);

    // Response FIFO full: keep reads blocked, discard reads still flow.
    for (int i = 0; i < 8; i++) begin
      req_read = 1'b1; req_keep = 1'b1; req_address = 64'h20 + 64'(i);
      #1 check("keep_credit_ok", 64'(req_wait), 0);
      @(negedge clk);
    end
    idle_req();
    for (int i = 0; i < 8; i++) begin
      man_rdv = 1'b1; man_rdata = 64'd100 + 64'(i);
      @(negedge clk);
    end
    man_rdv = 1'b0;
    req_read = 1'b1; req_keep = 1'b1;
    #1 check("keep_blocked", 64'(req_wait), 1);
    req_keep = 1'b0;
    #1 check("discard_allowed", 64'(req_wait), 0);
    @(negedge clk); idle_req();
    @(negedge clk); man_rdv = 1'b1; man_rdata = 64'hdead;
    @(negedge clk); man_rdv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("keep_order", rsp_data, 64'd100 + 64'(i));
      man_ack = 1'b1;
      @(negedge clk);
    end
    man_ack = 1'b0;
    check("keep_all_acked", 64'(rsp_valid), 0);
    req_read = 1'b1; req_keep = 1'b1;
    #1 check("keep_credit_restored", 64'(req_wait), 0);
    #1 idle_req();

    // Stray return and dual request.
    @(negedge clk); man_rdv = 1'b1;
    @(negedge clk); man_rdv = 1'b0;
    check("stray_flag", 64'(err_unexpected_rdv), 1);
    check("stray_outstanding", 64'(outstanding), 0);
    check("stray_no_rsp", 64'(rsp_valid), 0);
    req_read = 1'b1; req_write = 1'b1; req_address = 64'h55; req_wdata = 64'h1234;
    @(negedge clk); idle_req();
    check("dual_write", 64'({avm_write, avm_read}), 64'b10);
    check("dual_wdata", avm_writedata, 64'h1234);
    check("dual_flag", 64'(err_dual_req), 1);

    // Mid-operation reset with 3 reads in flight and 2 responses queued.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_read = 1'b1; req_keep = (i < 2); req_address = 64'h30 + 64'(i);
      @(negedge clk);
    end
    idle_req(); man_rdv = 1'b1;
    @(negedge clk); @(negedge clk); man_rdv = 1'b0;
    check("pre_rst_outstanding", 64'(outstanding), 3);
    check("pre_rst_rsp", 64'(rsp_valid), 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_rst_outstanding", 64'(outstanding), 0);
    check("mid_rst_rsp", 64'(rsp_valid), 0);
    check("mid_rst_strobes", 64'({avm_read, avm_write}), 0);
    check("mid_rst_flags", 64'({err_unexpected_rdv, err_dual_req}), 0);
    check("mid_rst_req_wait", 64'(req_wait), 0);
    man_rdv = 1'b1;
    @(negedge clk); man_rdv = 1'b0;
    check("post_rst_stray", 64'(err_unexpected_rdv), 1);

    // Randomized traffic through the controller model and scoreboard.
    do_reset();
    #2 ctrl_auto = 1'b1; mon_en = 1'b1;
    pending = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!pending) begin
        kind = int'($urandom_range(0, 3));
        req_address = {32'($urandom), 28'h0, 4'($urandom_range(0, 15))};
        req_wdata   = {32'($urandom), 32'($urandom)};
        req_write   = (kind == 1);
        req_read    = (kind >= 2);
        req_keep    = 1'($urandom_range(0, 1));
        pending     = (kind != 0);
      end
      #1;
      if (pending && !req_wait) begin
        key = req_address[24:0];
        if (req_write) ref_mem[key] = req_wdata;
        else if (req_keep) exp_q.push_back(ref_mem.exists(key) ? ref_mem[key] : mem_default(key));
        pending = 1'b0;
      end
    end
    @(negedge clk); idle_req();
    drained = 1'b0;
    for (int n = 0; n < 3000 && !drained; n++) begin
      @(negedge clk);
      drained = (exp_q.size() == 0) && (outstanding == 0) && (ctrl_due_q.size() == 0);
    end
    check("drain_done", 64'(drained), 1);
    check("final_outstanding", 64'(outstanding), 0);
    check("final_rsp_valid", 64'(rsp_valid), 0);
    check("final_flags", 64'({err_unexpected_rdv, err_dual_req}), 0);
    #2 ctrl_auto = 1'b0; mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
